seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the CPU's 8-bit combinational ALU.
- Adds SUB and bitwise ops, registered Zero/Carry/Neg flags, and an iterative one-bit-per-cycle shifter (no barrel shifter).
- Valid/ready handshakes on both input and output let the CPU control FSM stall on shifts.
- Sits between the register-file read stage and writeback.

---
 rtl/seq_alu.sv | 192 +++++++++++++++++++
 tb/tb_seq_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, registered flags and an
// iterative one-bit-per-cycle shifter.
module seq_alu #(
    parameter int unsigned W   = 8,
    parameter int unsigned OPS = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [OPS-1:0] OP,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out,
    output logic           Zero,
    output logic           Carry,
    output logic           Neg
);

    localparam int unsigned CW    = $clog2(W);
    localparam logic [W-1:0] W_LIM = W'(W);

    localparam logic [OPS-1:0] OP_ADD    = OPS'(0);
    localparam logic [OPS-1:0] OP_SHR    = OPS'(1);
    localparam logic [OPS-1:0] OP_SHL    = OPS'(2);
    localparam logic [OPS-1:0] OP_PARINS = OPS'(3);
    localparam logic [OPS-1:0] OP_SUB    = OPS'(4);
    localparam logic [OPS-1:0] OP_AND    = OPS'(5);
    localparam logic [OPS-1:0] OP_OR     = OPS'(6);
    localparam logic [OPS-1:0] OP_XOR    = OPS'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          shl_q, shl_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic          neg_q, neg_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [W-1:0]  r;
    logic          c;
    logic          fin;
    logic [W-1:0]  sh_nxt;

    // State and datapath registers; res_q doubles as the shift accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            cnt_q       <= '0;
            shl_q       <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            shl_q       <= shl_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, result and flag computation.
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        shl_d       = shl_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        r           = '0;
        c           = 1'b0;
        fin         = 1'b0;
        sh_nxt      = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (OP)
                        OP_ADD: begin
                            {c, r} = {1'b0, A} + {1'b0, B};
                            fin    = 1'b1;
                        end
                        OP_SHR, OP_SHL: begin
                            if (B == '0) begin
                                r   = A;
                                fin = 1'b1;
                            end else if (B >= W_LIM) begin
                                r   = '0;
                                fin = 1'b1;
                            end else begin
                                res_d      = A;
                                cnt_d      = CW'(B);
                                shl_d      = (OP == OP_SHL);
                                carry_d    = 1'b0;
                                in_ready_d = 1'b0;
                                state_d    = S_SHIFT;
                            end
                        end
                        OP_PARINS: begin
                            r = A;
                            if (B < W_LIM) begin
                                r[B[CW-1:0]] = ^A;
                            end
                            fin = 1'b1;
                        end
                        OP_SUB: begin
                            r   = A - B;
                            c   = (A < B);
                            fin = 1'b1;
                        end
                        OP_AND: begin
                            r   = A & B;
                            fin = 1'b1;
                        end
                        OP_OR: begin
                            r   = A | B;
                            fin = 1'b1;
                        end
                        OP_XOR: begin
                            r   = A ^ B;
                            fin = 1'b1;
                        end
                        default: begin
                            r   = '0;
                            fin = 1'b1;
                        end
                    endcase
                    if (fin) begin
                        res_d       = r;
                        carry_d     = c;
                        zero_d      = (r == '0);
                        neg_d       = r[W-1];
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                sh_nxt  = shl_q ? {res_q[W-2:0], 1'b0} : {1'b0, res_q[W-1:1]};
                carry_d = shl_q ? res_q[W-1] : res_q[0];
                res_d   = sh_nxt;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    zero_d      = (sh_nxt == '0);
                    neg_d       = sh_nxt[W-1];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out       = res_q;
    assign Carry     = carry_q;
    assign Zero      = zero_q;
    assign Neg       = neg_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu: literal expectations per vector plus a
// behavioural model compared on every cycle out_valid is high.
module tb_seq_alu;

    localparam int W = 8;

    localparam logic [2:0] ADD = 3'd0, SHR = 3'd1, SHL = 3'd2, PARINS = 3'd3;
    localparam logic [2:0] SUB = 3'd4, AND_ = 3'd5, OR_ = 3'd6, XOR_ = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [2:0]   OP;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         Zero, Carry, Neg;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_out;
    logic         exp_c, exp_z, exp_n;

    seq_alu #(.W(W), .OPS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .OP(OP),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .Zero(Zero), .Carry(Carry), .Neg(Neg)
    );

    always #5 clk = ~clk;

    // Reference behaviour written directly from the opcode definitions.
    task automatic model(input logic [2:0] op, input int a, input int b,
                         output int r, output int c);
        int p;
        r = 0;
        c = 0;
        case (op)
            ADD:  begin r = (a + b) % 256; c = (a + b >= 256) ? 1 : 0; end
            SUB:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            SHR:  begin
                if (b == 0) r = a;
                else if (b >= W) r = 0;
                else begin r = a >> b; c = (a >> (b - 1)) & 1; end
            end
            SHL:  begin
                if (b == 0) r = a;
                else if (b >= W) r = 0;
                else begin r = (a << b) & 255; c = (a >> (W - b)) & 1; end
            end
            PARINS: begin
                p = $countones(a) % 2;
                r = a;
                if (b < W) r = (a & ~(1 << b) & 255) | (p << b);
            end
            AND_: r = a & b;
            OR_:  r = a | b;
            default: r = a ^ b;
        endcase
    endtask

    function automatic int model_lat(input logic [2:0] op, input int b);
        if ((op == SHR || op == SHL) && b >= 1 && b < W) return b + 1;
        return 1;
    endfunction

    task automatic set_exp(input logic [2:0] op, input int a, input int b);
        int r, c;
        model(op, a, b, r, c);
        exp_out = W'(r);
        exp_c   = c[0];
        exp_z   = (r == 0);
        exp_n   = r[W-1];
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Model comparison on every cycle the result is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (out !== exp_out || Carry !== exp_c || Zero !== exp_z || Neg !== exp_n) begin
                errors++;
                $display("FAIL model: out=%h C=%b Z=%b N=%b expected out=%h C=%b Z=%b N=%b",
                         out, Carry, Zero, Neg, exp_out, exp_c, exp_z, exp_n);
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input logic [7:0] lo, input logic lc,
                          input logic lz, input logic ln);
        int lat, busy, elat;
        @(negedge clk);
        A = a; B = b; OP = op; in_valid = 1'b1;
        set_exp(op, int'(a), int'(b));
        elat = model_lat(op, int'(b));
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); OP = 3'($urandom);
        lat = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready) busy++;
        end while (!out_valid && lat < 40);
        chk("latency", lat, elat);
        chk("lit_out", int'(out), int'(lo));
        chk("lit_carry", int'(Carry), int'(lc));
        chk("lit_zero", int'(Zero), int'(lz));
        chk("lit_neg", int'(Neg), int'(ln));
        repeat (hold) begin
            @(negedge clk);
            if (!in_ready) busy++;
        end
        chk("valid_held", int'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_ready", int'(in_ready), 1);
        chk("busy_cycles", busy, elat + hold);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; OP = '0;
        exp_out = '0; exp_c = 1'b0; exp_z = 1'b0; exp_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out", int'(out), 0);
        chk("rst_flags", int'({Zero, Carry, Neg}), 0);
        rst_n = 1'b1;

        run_op(ADD,    8'hF0, 8'h20, 0, 8'h10, 1'b1, 1'b0, 1'b0);
        run_op(SUB,    8'h05, 8'h07, 0, 8'hFE, 1'b1, 1'b0, 1'b1);
        run_op(SHL,    8'h81, 8'd3,  0, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op(SHR,    8'h81, 8'd1,  0, 8'h40, 1'b1, 1'b0, 1'b0);
        run_op(SHR,    8'h81, 8'd8,  0, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(SHL,    8'h5A, 8'd0,  0, 8'h5A, 1'b0, 1'b0, 1'b0);
        run_op(PARINS, 8'h07, 8'd7,  0, 8'h87, 1'b0, 1'b0, 1'b1);
        run_op(PARINS, 8'h07, 8'd9,  0, 8'h07, 1'b0, 1'b0, 1'b0);
        run_op(PARINS, 8'h03, 8'd0,  0, 8'h02, 1'b0, 1'b0, 1'b0);
        run_op(AND_,   8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op(OR_,    8'hF0, 8'h0F, 2, 8'hFF, 1'b0, 1'b0, 1'b1);
        run_op(SUB,    8'h33, 8'h33, 0, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(SHL,    8'hC3, 8'd7,  1, 8'h80, 1'b1, 1'b0, 1'b1);
        run_op(SHR,    8'hC3, 8'd7,  0, 8'h01, 1'b1, 1'b0, 1'b0);
        run_op(ADD,    8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op(SHR,    8'h80, 8'hFF, 0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure with a competing request held during DONE.
        @(negedge clk);
        A = 8'hFF; B = 8'hFF; OP = XOR_; in_valid = 1'b1;
        set_exp(XOR_, 255, 255);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_out", int'(out), 0);
            chk("bp_zero", int'(Zero), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            A = 8'h01; B = 8'h02; OP = ADD; in_valid = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_ready", int'(in_ready), 1);
        chk("bp_release_valid", int'(out_valid), 0);
        set_exp(ADD, 1, 2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", int'(out_valid), 1);
        chk("bp_second_out", int'(out), 3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Asynchronous reset during the third SHIFT cycle.
        @(negedge clk);
        A = 8'h01; B = 8'd6; OP = SHL; in_valid = 1'b1;
        set_exp(SHL, 1, 6);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_out", int'(out), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_carry", int'(Carry), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(ADD, 8'h01, 8'h01, 0, 8'h02, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
